decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
- Pipelined successor to the single-cycle main controller. Decodes the IF/ID instruction into the full control bundle and registers it into the ID/EX stage.
- Adds three things the single-cycle controller lacks: load-use hazard stall, multi-cycle multiply hold, and branch flush.
- Parametrised in ALUOp width and multiply latency. Sits between the IF/ID register and the EX stage of the 5-stage datapath.

Parameters:
- ALUOP_W, 5: width of ALUOp field; the 5-bit codes below are zero-extended (must be >= 5).
- MUL_CYCLES, 3: EX occupancy of MulOp instructions in cycles; 1 means no hold.
- MUL_CNT_W, 2: width of the multiply hold counter; must hold MUL_CYCLES-1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- instr  in  32  IF/ID instruction word.
- flush  in  1  taken branch/jump resolved; kill the instruction in ID.
- stall  out  1  combinational; IF/ID and PC must hold this cycle.
- ex_valid  out  1  ID/EX slot holds a real instruction.
- ex_regDst, ex_ALUSource, ex_MemToReg, ex_regWrite, ex_MemRead, ex_MemWrite, ex_Jump, ex_MulOp  out  1 each  registered control bits, same meanings as the single-cycle controller.
  - regDst: 1 = rt, 0 = rd.
  - MemToReg: 1 = ALU result, 0 = memory data.
- ex_BranchJump  out  3  branch class.
- ex_ALUOp  out  ALUOP_W  ALU operation code.
- ex_MemDataType  out  2  memory width: 00 byte, 01 half, 10 word.
- ex_wreg  out  5  resolved destination register.
- illegal_op  out  1  sticky flag; exists only with the optional feature.

Behaviour:
- Reset: all ex_* outputs go to 0, the hold counter goes to 0, illegal_op goes to 0, and stall reads 0.
- Latency: one cycle. The control bundle for the instruction in ID appears on ex_* after the next rising edge.
- Decode table, keyed on opcode = instr[31:26]. Every bit not listed is 0. Register-writing entries set regWrite=1.
  - 000000 R-type: MemToReg=1, ALUOp=00000, wreg=rd. MulOp=1 iff funct = 011000 or 011001.
  - addi 001000: ALUOp 00010.
  - addiu 001001: ALUOp 00111.
  - andi 001100: ALUOp 00001.
  - ori 001101: ALUOp 00011.
  - xori 001110: ALUOp 00100.
  - slti 001010: ALUOp 00101.
  - sltiu 001011: ALUOp 01011.
  - lui 001111: ALUOp 10100.
  - Common to all immediate ops above: regDst=1, ALUSource=1, MemToReg=1, wreg=rt.
  - 011100 special2: MemToReg=1, MulOp=1, ALUOp 01000, wreg=rd.
  - 011111 special3: MemToReg=1, ALUOp 01001, wreg=rd.
  - Loads lb 100000 / lh 100001 / lw 100011: regDst=1, ALUSource=1, MemRead=1, ALUOp 00010, MemDataType 00/01/10, wreg=rt.
  - Stores sb 101000 / sh 101001 / sw 101011: ALUSource=1, MemWrite=1, ALUOp 00010, MemDataType 00/01/10, regWrite=0.
  - Branches: Jump=1, ALUOp 00110.
    - BranchJump = beq 001, bne 010, 000001 100, bgtz 101, blez 110.
    - j/jal: BranchJump = 011.
    - jal additionally sets regWrite=1 and wreg=31.
  - Any other opcode decodes as a bubble (all 0).
- Load-use stall:
  - Condition: ex_valid & ex_MemRead & ex_wreg != 0, and ex_wreg matches either:
    - instr rs (instr[25:21]), or
    - instr rt (instr[20:16]) when the ID instruction reads rt (R-type, special2, special3, beq, bne, stores).
  - Effect: stall=1 for exactly one cycle, and a bubble is loaded into ID/EX.
- Multiply hold:
  - When a valid MulOp instruction is loaded into ID/EX, the counter loads MUL_CYCLES-1.
  - While the counter != 0: stall=1, the ID/EX contents hold unchanged, and the counter decrements each cycle.
  - Total stall cycles = MUL_CYCLES-1.
- Priority, highest first: Reset > flush > multiply hold > load-use > normal load.
  - flush loads a bubble and clears the counter, including mid-hold.
- if_valid=0 or flush=1: ID/EX receives a bubble (ex_valid=0, every control bit 0). Stall is not asserted for invalid slots.
- stall and flush asserted in the same cycle: flush wins and stall drops to 0.
- Reset asserted mid-hold clears everything immediately, without waiting for a clock edge.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
  - Defined: an unrecognised opcode with if_valid=1 and no flush sets illegal_op=1 on the next edge. It stays set until Reset, and the instruction still enters as a bubble.
  - Undefined: the illegal_op port is absent, and unrecognised opcodes are silently bubbled.

Test Plan:
- Reset mid-run, then release; apply addi $8,$9,5 (0x21280005) with if_valid=1 -> next edge: ex_valid=1, ex_ALUOp=00010, ex_regDst=1, ex_ALUSource=1, ex_regWrite=1, ex_wreg=8.
- lw $8,0($9) then add $10,$8,$11 -> during the add: stall=1 for one cycle and a bubble enters EX; on the following edge the add loads with ex_wreg=10.
- mul (opcode 011100) with MUL_CYCLES=3 -> stall=1 for 2 cycles, ex_MulOp held at 1 throughout, then the next instruction loads.
- flush=1 during cycle 1 of the mul hold -> next edge: ex_valid=0, counter=0, stall=0.
- jal (0x0C000010) -> ex_Jump=1, ex_BranchJump=011, ex_regWrite=1, ex_wreg=31.
- With DECODE_ILLEGAL_TRAP_EN defined: opcode 111111 -> illegal_op=1 and ex_valid=0; illegal_op stays 1 through subsequent valid instructions until Reset.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// ID-stage decoder: IF/ID instruction -> ID/EX control bundle, with load-use
// stall, multiply hold and flush. Optional macro: DECODE_ILLEGAL_TRAP_EN.
module decode_ctrl_pipe #(
    parameter int ALUOP_W    = 5,
    parameter int MUL_CYCLES = 3,
    parameter int MUL_CNT_W  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               if_valid,
    input  logic [31:0]        instr,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_regDst,
    output logic               ex_ALUSource,
    output logic               ex_MemToReg,
    output logic               ex_regWrite,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_Jump,
    output logic               ex_MulOp,
    output logic [2:0]         ex_BranchJump,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [1:0]         ex_MemDataType,
    output logic [4:0]         ex_wreg
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               jump;
        logic               mulop;
        logic [2:0]         bj;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         mdt;
        logic [4:0]         wreg;
    } ctrl_t;

    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 1);

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    ctrl_t      d, ex_q;
    logic       reads_rt, legal, is_imm;
    logic       hold, load_use;
    logic [MUL_CNT_W-1:0] mul_cnt;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    function automatic logic [ALUOP_W-1:0] op(input logic [4:0] c);
        return ALUOP_W'(c);
    endfunction

    // Combinational decode of the instruction currently in ID.
    always_comb begin
        d        = '0;
        reads_rt = 1'b0;
        legal    = 1'b1;
        is_imm   = 1'b0;
        unique case (opcode)
            6'b000000: begin
                d.memtoreg = 1'b1;
                d.regwrite = 1'b1;
                d.wreg     = rd;
                d.mulop    = (funct == 6'b011000) || (funct == 6'b011001);
                reads_rt   = 1'b1;
            end
            6'b001000: begin is_imm = 1'b1; d.aluop = op(5'b00010); end
            6'b001001: begin is_imm = 1'b1; d.aluop = op(5'b00111); end
            6'b001100: begin is_imm = 1'b1; d.aluop = op(5'b00001); end
            6'b001101: begin is_imm = 1'b1; d.aluop = op(5'b00011); end
            6'b001110: begin is_imm = 1'b1; d.aluop = op(5'b00100); end
            6'b001010: begin is_imm = 1'b1; d.aluop = op(5'b00101); end
            6'b001011: begin is_imm = 1'b1; d.aluop = op(5'b01011); end
            6'b001111: begin is_imm = 1'b1; d.aluop = op(5'b10100); end
            6'b011100: begin
                d.memtoreg = 1'b1;
                d.regwrite = 1'b1;
                d.mulop    = 1'b1;
                d.aluop    = op(5'b01000);
                d.wreg     = rd;
                reads_rt   = 1'b1;
            end
            6'b011111: begin
                d.memtoreg = 1'b1;
                d.regwrite = 1'b1;
                d.aluop    = op(5'b01001);
                d.wreg     = rd;
                reads_rt   = 1'b1;
            end
            6'b100000, 6'b100001, 6'b100011: begin
                d.regdst   = 1'b1;
                d.alusrc   = 1'b1;
                d.memread  = 1'b1;
                d.regwrite = 1'b1;
                d.aluop    = op(5'b00010);
                d.mdt      = opcode[1] ? 2'b10 : {1'b0, opcode[0]};
                d.wreg     = rt;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                d.alusrc   = 1'b1;
                d.memwrite = 1'b1;
                d.aluop    = op(5'b00010);
                d.mdt      = opcode[1] ? 2'b10 : {1'b0, opcode[0]};
                reads_rt   = 1'b1;
            end
            6'b000100: begin
                d.jump = 1'b1; d.aluop = op(5'b00110); d.bj = 3'b001;
                reads_rt = 1'b1;
            end
            6'b000101: begin
                d.jump = 1'b1; d.aluop = op(5'b00110); d.bj = 3'b010;
                reads_rt = 1'b1;
            end
            6'b000001: begin d.jump = 1'b1; d.aluop = op(5'b00110); d.bj = 3'b100; end
            6'b000111: begin d.jump = 1'b1; d.aluop = op(5'b00110); d.bj = 3'b101; end
            6'b000110: begin d.jump = 1'b1; d.aluop = op(5'b00110); d.bj = 3'b110; end
            6'b000010: begin d.jump = 1'b1; d.aluop = op(5'b00110); d.bj = 3'b011; end
            6'b000011: begin
                d.jump     = 1'b1;
                d.aluop    = op(5'b00110);
                d.bj       = 3'b011;
                d.regwrite = 1'b1;
                d.wreg     = 5'd31;
            end
            default: legal = 1'b0;
        endcase
        if (is_imm) begin
            d.regdst   = 1'b1;
            d.alusrc   = 1'b1;
            d.memtoreg = 1'b1;
            d.regwrite = 1'b1;
            d.wreg     = rt;
        end
    end

    // Hazard detection; a flush overrides any stall.
    always_comb begin
        hold     = (mul_cnt != '0);
        load_use = if_valid && ex_valid && ex_q.memread && (ex_q.wreg != 5'd0) &&
                   ((ex_q.wreg == rs) || (reads_rt && (ex_q.wreg == rt)));
        stall    = !flush && (hold || load_use);
    end

    // ID/EX register and multiply hold counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_q     <= '0;
            ex_valid <= 1'b0;
            mul_cnt  <= '0;
        end else if (flush) begin
            ex_q     <= '0;
            ex_valid <= 1'b0;
            mul_cnt  <= '0;
        end else if (hold) begin
            mul_cnt  <= mul_cnt - MUL_CNT_W'(1);
        end else if (load_use || !if_valid || !legal) begin
            ex_q     <= '0;
            ex_valid <= 1'b0;
            mul_cnt  <= '0;
        end else begin
            ex_q     <= d;
            ex_valid <= 1'b1;
            mul_cnt  <= d.mulop ? MUL_LOAD : '0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Sticky flag for an unrecognised opcode seen in a live ID slot.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            illegal_op <= 1'b0;
        else if (if_valid && !flush && !legal)
            illegal_op <= 1'b1;
    end
`endif

    assign ex_regDst      = ex_q.regdst;
    assign ex_ALUSource   = ex_q.alusrc;
    assign ex_MemToReg    = ex_q.memtoreg;
    assign ex_regWrite    = ex_q.regwrite;
    assign ex_MemRead     = ex_q.memread;
    assign ex_MemWrite    = ex_q.memwrite;
    assign ex_Jump        = ex_q.jump;
    assign ex_MulOp       = ex_q.mulop;
    assign ex_BranchJump  = ex_q.bj;
    assign ex_ALUOp       = ex_q.aluop;
    assign ex_MemDataType = ex_q.mdt;
    assign ex_wreg        = ex_q.wreg;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe (default parameters).
// Covers the DECODE_ILLEGAL_TRAP_EN build when that macro is defined.
module tb_decode_ctrl_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        if_valid;
    logic [31:0] instr;
    logic        flush;
    logic        stall;
    logic        ex_valid, ex_regDst, ex_ALUSource, ex_MemToReg, ex_regWrite;
    logic        ex_MemRead, ex_MemWrite, ex_Jump, ex_MulOp;
    logic [2:0]  ex_BranchJump;
    logic [4:0]  ex_ALUOp;
    logic [1:0]  ex_MemDataType;
    logic [4:0]  ex_wreg;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ADDI   = 32'h2128_0005; // addi $8,$9,5
    localparam logic [31:0] LW8    = 32'h8D28_0000; // lw $8,0($9)
    localparam logic [31:0] LW0    = 32'h8D20_0000; // lw $0,0($9)
    localparam logic [31:0] ADD_RS = 32'h010B_5020; // add $10,$8,$11
    localparam logic [31:0] ADD_RT = 32'h0168_5020; // add $10,$11,$8
    localparam logic [31:0] ADD_Z  = 32'h000B_5020; // add $10,$0,$11
    localparam logic [31:0] MUL    = 32'h710B_5002; // mul $10,$8,$11
    localparam logic [31:0] JAL    = 32'h0C00_0010;
    localparam logic [31:0] SW     = 32'hAD28_0004; // sw $8,4($9)
    localparam logic [31:0] BEQ    = 32'h1109_0003; // beq $8,$9,3
    localparam logic [31:0] ILL    = 32'hFC00_0000;

    logic [23:0] got;
    assign got = {ex_valid, ex_regDst, ex_ALUSource, ex_MemToReg, ex_regWrite,
                  ex_MemRead, ex_MemWrite, ex_Jump, ex_MulOp, ex_BranchJump,
                  ex_ALUOp, ex_MemDataType, ex_wreg};

    function automatic logic [23:0] bun(
        input logic v, rdst, asrc, m2r, rw, mr, mw, j, mul,
        input logic [2:0] bj, input logic [4:0] aop,
        input logic [1:0] mdt, input logic [4:0] wr);
        return {v, rdst, asrc, m2r, rw, mr, mw, j, mul, bj, aop, mdt, wr};
    endfunction

    logic [23:0] E_ADDI, E_LW8, E_ADD, E_MUL, E_JAL, E_SW, E_BEQ;

    decode_ctrl_pipe dut (
        .Clk(Clk), .Reset(Reset), .if_valid(if_valid), .instr(instr),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_regDst(ex_regDst), .ex_ALUSource(ex_ALUSource),
        .ex_MemToReg(ex_MemToReg), .ex_regWrite(ex_regWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Jump(ex_Jump), .ex_MulOp(ex_MulOp),
        .ex_BranchJump(ex_BranchJump), .ex_ALUOp(ex_ALUOp),
        .ex_MemDataType(ex_MemDataType), .ex_wreg(ex_wreg)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    always #5 Clk = ~Clk;

    // Present an ID slot on the falling edge, settle combinational logic.
    task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
        @(negedge Clk);
        if_valid = v;
        instr    = ins;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, ADDI, 1'b0);
        tick();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        total++;
        if (got !== 24'h0) begin bad++; $display("FAIL reset_bundle got=%h want=%h", got, 24'h0); end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_addi();
        drive(1'b1, ADDI, 1'b0);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL addi_stall got=%b want=0", stall); end
        tick();
        total++;
        if (got !== E_ADDI) begin bad++; $display("FAIL addi got=%h want=%h", got, E_ADDI); end
    endtask

    task automatic test_load_use(input logic [31:0] user, input string nm);
        drive(1'b1, LW8, 1'b0);
        tick();
        total++;
        if (got !== E_LW8) begin bad++; $display("FAIL %s_lw got=%h want=%h", nm, got, E_LW8); end
        drive(1'b1, user, 1'b0);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall got=%b want=1", nm, stall); end
        tick();
        total++;
        if (got !== 24'h0) begin bad++; $display("FAIL %s_bubble got=%h want=0", nm, got); end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL %s_stall_drop got=%b want=0", nm, stall); end
        tick();
        total++;
        if (got !== E_ADD) begin bad++; $display("FAIL %s_add got=%h want=%h", nm, got, E_ADD); end
    endtask

    task automatic test_no_hazard();
        drive(1'b1, LW8, 1'b0);
        tick();
        drive(1'b1, ADDI, 1'b0);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL rt_not_read_stall got=%b want=0", stall); end
        drive(1'b1, LW0, 1'b0);
        tick();
        drive(1'b1, ADD_Z, 1'b0);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b want=0", stall); end
        tick();
        total++;
        if (got !== E_ADD) begin bad++; $display("FAIL r0_add got=%h want=%h", got, E_ADD); end
    endtask

    task automatic test_mul_hold();
        drive(1'b1, MUL, 1'b0);
        tick();
        total++;
        if (got !== E_MUL) begin bad++; $display("FAIL mul_load got=%h want=%h", got, E_MUL); end
        drive(1'b1, ADDI, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL mul_stall%0d got=%b want=1", i, stall); end
            tick();
            total++;
            if (got !== E_MUL) begin bad++; $display("FAIL mul_held%0d got=%h want=%h", i, got, E_MUL); end
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL mul_release got=%b want=0", stall); end
        tick();
        total++;
        if (got !== E_ADDI) begin bad++; $display("FAIL mul_next got=%h want=%h", got, E_ADDI); end
    endtask

    task automatic test_flush_hold();
        drive(1'b1, MUL, 1'b0);
        tick();
        drive(1'b1, ADDI, 1'b1);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL flush_beats_stall got=%b want=0", stall); end
        tick();
        total++;
        if (got !== 24'h0) begin bad++; $display("FAIL flush_bubble got=%h want=0", got); end
        drive(1'b1, ADDI, 1'b0);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL flush_cnt_clear got=%b want=0", stall); end
        tick();
        total++;
        if (got !== E_ADDI) begin bad++; $display("FAIL flush_next got=%h want=%h", got, E_ADDI); end
    endtask

    task automatic test_reset_mid_hold();
        drive(1'b1, MUL, 1'b0);
        tick();
        drive(1'b1, ADDI, 1'b0);
        Reset = 1'b1;
        #1;
        total++;
        if ({stall, got} !== 25'h0) begin
            bad++; $display("FAIL reset_mid_hold got=%h want=0", {stall, got});
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_cnt_clear got=%b want=0", stall); end
    endtask

    task automatic test_decode_misc();
        logic [31:0] ins [4] = '{JAL, SW, BEQ, ADDI};
        logic [23:0] exp [4] = '{E_JAL, E_SW, E_BEQ, 24'h0};
        for (int i = 0; i < 4; i++) begin
            drive(i != 3, ins[i], 1'b0);
            tick();
            total++;
            if (got !== exp[i]) begin bad++; $display("FAIL decode%0d got=%h want=%h", i, got, exp[i]); end
        end
        drive(1'b1, ADDI, 1'b1);
        tick();
        total++;
        if (got !== 24'h0) begin bad++; $display("FAIL flush_plain got=%h want=0", got); end
    endtask

    task automatic test_illegal();
        drive(1'b1, ILL, 1'b0);
        tick();
        total++;
        if (got !== 24'h0) begin bad++; $display("FAIL illegal_bubble got=%h want=0", got); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        total++;
        if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_set got=%b want=1", illegal_op); end
        drive(1'b1, ADDI, 1'b0);
        tick();
        total++;
        if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b want=1", illegal_op); end
        total++;
        if (got !== E_ADDI) begin bad++; $display("FAIL illegal_after got=%h want=%h", got, E_ADDI); end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        total++;
        if (illegal_op !== 1'b0) begin bad++; $display("FAIL illegal_reset got=%b want=0", illegal_op); end
        @(negedge Clk);
        Reset = 1'b0;
`else
        drive(1'b1, ADDI, 1'b0);
        tick();
        total++;
        if (got !== E_ADDI) begin bad++; $display("FAIL illegal_after got=%h want=%h", got, E_ADDI); end
`endif
    endtask

    initial begin
        E_ADDI = bun(1, 1, 1, 1, 1, 0, 0, 0, 0, 3'b000, 5'b00010, 2'b00, 5'd8);
        E_LW8  = bun(1, 1, 1, 0, 1, 1, 0, 0, 0, 3'b000, 5'b00010, 2'b10, 5'd8);
        E_ADD  = bun(1, 0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 5'b00000, 2'b00, 5'd10);
        E_MUL  = bun(1, 0, 0, 1, 1, 0, 0, 0, 1, 3'b000, 5'b01000, 2'b00, 5'd10);
        E_JAL  = bun(1, 0, 0, 0, 1, 0, 0, 1, 0, 3'b011, 5'b00110, 2'b00, 5'd31);
        E_SW   = bun(1, 0, 1, 0, 0, 0, 1, 0, 0, 3'b000, 5'b00010, 2'b10, 5'd0);
        E_BEQ  = bun(1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b001, 5'b00110, 2'b00, 5'd0);
        Reset    = 1'b1;
        if_valid = 1'b0;
        instr    = 32'h0;
        flush    = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        test_reset();
        test_addi();
        test_load_use(ADD_RS, "lu_rs");
        test_load_use(ADD_RT, "lu_rt");
        test_no_hazard();
        test_mul_hold();
        test_flush_hold();
        test_reset_mid_hold();
        test_decode_misc();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
